// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: synchronised, debounced switch reader with sticky change flags on a strobe bus.
// Define SW_IRQ_EN to add the irq mask register (0xC) and a registered level interrupt.
module sw_input_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int BUS_WIDTH       = 32,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [3:0]           addr,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic [BUS_WIDTH-1:0] sw_pro,
    output logic                 irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]  sync1_q, sync2_q, stable_q, stable_d, flags_q, flags_d, set, w1c, rd_sel, mask_rd;
    logic [CW-1:0]        cnt_q [SW_WIDTH];
    logic [CW-1:0]        cnt_d [SW_WIDTH];
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 unused_bits;

    always_comb begin
        stable_d = stable_q;
        set      = '0;
        for (int i = 0; i < SW_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    set[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // a debounce set in the same cycle as a W1C of that bit must win
    always_comb begin
        w1c     = (wr_en && addr[3:2] == 2'd1) ? wdata[SW_WIDTH-1:0] : '0;
        flags_d = (flags_q & ~w1c) | set;
        rd_sel  = addr[3:2] == 2'd0 ? stable_q :
                  addr[3:2] == 2'd1 ? flags_q  :
                  addr[3:2] == 2'd2 ? sync2_q  : mask_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            flags_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < SW_WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= sw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            flags_q  <= flags_d;
            rdata_q  <= rd_en ? BUS_WIDTH'(rd_sel) : rdata_q;
            for (int i = 0; i < SW_WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef SW_IRQ_EN
    logic [SW_WIDTH-1:0] mask_q, mask_d;
    logic                irq_q;

    assign mask_d  = (wr_en && addr[3:2] == 2'd3) ? wdata[SW_WIDTH-1:0] : mask_q;
    assign mask_rd = mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(flags_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    assign unused_bits = ^{wdata, addr[1:0]};
    assign rdata       = rdata_q;
    assign sw_pro      = BUS_WIDTH'(stable_q);
endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb_sw_input_ctrl: directed bench for sw_input_ctrl with DEBOUNCE_CYCLES=4, SW_WIDTH=16.
module tb_sw_input_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, sw_pro;
    logic        irq;
    int          tests = 0;
    int          fails = 0;

    sw_input_ctrl #(.SW_WIDTH(16), .BUS_WIDTH(32), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .sw_pro(sw_pro), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [3:0] a);
        rd_en = 1'b1;
        addr  = a;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        sw = 16'hFFFF;
        tick(3);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
        tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL reset_sw_pro got %h exp %h", sw_pro, 32'h0); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", irq); end
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL reset_hold_edge%0d got %h exp %h", e, sw_pro, 32'h0); end
        end
        tick(1);
        tests++; if (sw_pro !== 32'h0000FFFF) begin fails++; $display("FAIL reset_acquire got %h exp %h", sw_pro, 32'h0000FFFF); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0000FFFF) begin fails++; $display("FAIL reset_flags got %h exp %h", rdata, 32'h0000FFFF); end
    endtask

    task automatic test_glitch;
        sw = 16'h0000;
        tick(8);
        bus_write(4'h4, 32'hFFFF);
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL glitch_pre_flags got %h exp %h", rdata, 32'h0); end
        sw = 16'h0008;
        tick(3);
        sw = 16'h0000;
        tick(10);
        tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL glitch_sw_pro got %h exp %h", sw_pro, 32'h0); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL glitch_flags got %h exp %h", rdata, 32'h0); end
    endtask

    task automatic test_pattern;
        sw = 16'h00A5;
        tick(2);
        bus_read(4'h8);
        tests++; if (rdata !== 32'h000000A5) begin fails++; $display("FAIL raw_sync got %h exp %h", rdata, 32'h000000A5); end
        tick(2);
        tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL pattern_edge5 got %h exp %h", sw_pro, 32'h0); end
        tick(1);
        tests++; if (sw_pro !== 32'h000000A5) begin fails++; $display("FAIL pattern_edge6 got %h exp %h", sw_pro, 32'h000000A5); end
        bus_write(4'h0, 32'h0);
        bus_read(4'h3);
        tests++; if (rdata !== 32'h000000A5) begin fails++; $display("FAIL stable_ro got %h exp %h", rdata, 32'h000000A5); end
        bus_read(4'h5);
        tests++; if (rdata !== 32'h000000A5) begin fails++; $display("FAIL pattern_flags got %h exp %h", rdata, 32'h000000A5); end
        tick(2);
        tests++; if (rdata !== 32'h000000A5) begin fails++; $display("FAIL rdata_hold got %h exp %h", rdata, 32'h000000A5); end
    endtask

    task automatic test_w1c;
        bus_write(4'h4, 32'hFFFF);
        sw = 16'h00AA;
        tick(8);
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0000000F) begin fails++; $display("FAIL w1c_setup got %h exp %h", rdata, 32'h0000000F); end
        bus_write(4'h4, 32'h5);
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0000000A) begin fails++; $display("FAIL w1c_partial got %h exp %h", rdata, 32'h0000000A); end
        sw = 16'h00AB;
        tick(5);
        bus_write(4'h4, 32'h3);
        tests++; if (sw_pro !== 32'h000000AB) begin fails++; $display("FAIL w1c_collide_sw_pro got %h exp %h", sw_pro, 32'h000000AB); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h00000009) begin fails++; $display("FAIL w1c_set_wins got %h exp %h", rdata, 32'h00000009); end
        rd_en = 1'b1;
        wr_en = 1'b1;
        addr  = 4'h4;
        wdata = 32'hFFFF;
        tick(1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        tests++; if (rdata !== 32'h00000009) begin fails++; $display("FAIL rdwr_prewrite got %h exp %h", rdata, 32'h00000009); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rdwr_cleared got %h exp %h", rdata, 32'h0); end
    endtask

    task automatic test_irq;
        bus_write(4'hC, 32'h1);
        bus_read(4'hC);
`ifdef SW_IRQ_EN
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL mask_read got %h exp %h", rdata, 32'h1); end
        sw = 16'h00AA;
        tick(6);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_flag_edge got %b exp 0", irq); end
        tick(1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_assert got %b exp 1", irq); end
        bus_write(4'h4, 32'h1);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_w1c_edge got %b exp 1", irq); end
        tick(1);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_deassert got %b exp 0", irq); end
`else
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL mask_absent got %h exp %h", rdata, 32'h0); end
        sw = 16'h00AA;
        tick(8);
        bus_write(4'h4, 32'h1);
        tick(1);
`endif
        sw = 16'h00A8;
        tick(10);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_unmasked_bit got %b exp 0", irq); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h2) begin fails++; $display("FAIL irq_bit1_flag got %h exp %h", rdata, 32'h2); end
    endtask

    task automatic test_reset_mid;
        sw = 16'h00A9;
        bus_read(4'h0);
        tests++; if (rdata !== 32'h000000A8) begin fails++; $display("FAIL mid_pre_read got %h exp %h", rdata, 32'h000000A8); end
        tick(3);
        rst_n = 1'b0;
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL mid_rdata got %h exp %h", rdata, 32'h0); end
        tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL mid_sw_pro got %h exp %h", sw_pro, 32'h0); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got %b exp 0", irq); end
        tick(1);
        rst_n = 1'b1;
        bus_read(4'h4);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL mid_flags got %h exp %h", rdata, 32'h0); end
        tick(4);
        tests++; if (sw_pro !== 32'h0) begin fails++; $display("FAIL mid_edge5 got %h exp %h", sw_pro, 32'h0); end
        tick(1);
        tests++; if (sw_pro !== 32'h000000A9) begin fails++; $display("FAIL mid_reacquire got %h exp %h", sw_pro, 32'h000000A9); end
        bus_read(4'h4);
        tests++; if (rdata !== 32'h000000A9) begin fails++; $display("FAIL mid_flags_after got %h exp %h", rdata, 32'h000000A9); end
        bus_read(4'hC);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL mid_mask got %h exp %h", rdata, 32'h0); end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_pattern;
        test_w1c;
        test_irq;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
